// File: rtl/car_led_pkg.sv
// Shared encodings and default parameters for the car LED driver.
// CAR_LED_PWM_EN adds the breathe states and the PWM dimming path.
package car_led_pkg;

   localparam int unsigned DEF_CLK_HZ   = 50_000_000;
   localparam int unsigned DEF_BLINK_HZ = 2;
   localparam int unsigned DEF_PWM_BITS = 8;
   localparam int unsigned DEF_STEP_DIV = 48828;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_STEADY  = 2'b01,
      MODE_BLINK   = 2'b10,
      MODE_BREATHE = 2'b11
   } mode_e;

   typedef logic [2:0] state_t;

   localparam state_t ST_OFF        = 3'd0;
   localparam state_t ST_STEADY     = 3'd1;
   localparam state_t ST_BLINK_A    = 3'd2;
   localparam state_t ST_BLINK_B    = 3'd3;
`ifdef CAR_LED_PWM_EN
   localparam state_t ST_BREATHE_UP = 3'd4;
   localparam state_t ST_BREATHE_DN = 3'd5;
`endif

   // Without the PWM path, breathe requests fall back to steady-on.
   function automatic state_t entry_state(mode_e m);
      state_t s;
      s = ST_OFF;
      case (m)
         MODE_STEADY:  s = ST_STEADY;
         MODE_BLINK:   s = ST_BLINK_A;
`ifdef CAR_LED_PWM_EN
         MODE_BREATHE: s = ST_BREATHE_UP;
`else
         MODE_BREATHE: s = ST_STEADY;
`endif
         default:      s = ST_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/car_led_pwm.sv
// Free-running PWM counter and level comparator; output high while counter < level.
// Only instantiated when CAR_LED_PWM_EN is defined.
module car_led_pwm
   import car_led_pkg::*;
#(
   parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PWM_BITS-1:0] level,
   output logic                pwm_out
);

   logic [PWM_BITS-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt <= '0;
      else          cnt <= cnt + PWM_BITS'(1);
   end

   assign pwm_out = (cnt < level);

endmodule

// File: rtl/car_led_driver.sv
// Two-LED driver: off / steady / blink / breathe selected by led_ctrl.
// Optional macro CAR_LED_PWM_EN enables PWM dimming and the breathe states.
//
// state      | meaning
// OFF        | both LEDs off
// STEADY     | both LEDs on (half-level PWM when dimming is enabled)
// BLINK_A    | LED0 on, flips to BLINK_B on half-period tick
// BLINK_B    | LED1 on, flips to BLINK_A on half-period tick
// BREATHE_UP | both LEDs at PWM level L, L rising one step per STEP_DIV cycles
// BREATHE_DN | both LEDs at PWM level L, L falling one step per STEP_DIV cycles
module car_led_driver
   import car_led_pkg::*;
#(
   parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
   parameter int unsigned BLINK_HZ = DEF_BLINK_HZ,
   parameter int unsigned PWM_BITS = DEF_PWM_BITS,
   parameter int unsigned STEP_DIV = DEF_STEP_DIV
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] led_ctrl,
   output logic [1:0] led_out,
   output logic       active
);

   localparam int unsigned HALF_PERIOD = CLK_HZ / (2 * BLINK_HZ);
   localparam int unsigned PRE_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(HALF_PERIOD - 1);

   if (PWM_BITS < 2 || STEP_DIV < 1 || HALF_PERIOD < 1) begin : g_param_check
      $error("car_led_driver: unsupported parameter combination");
   end

   logic [1:0]       rst_sync;
   logic             rst_s;
   mode_e            mode_q;
   mode_e            mode_cur;
   logic             mode_chg;
   state_t           state;
   state_t           state_nxt;
   logic [PRE_W-1:0] pre_cnt;
   logic [PRE_W-1:0] pre_nxt;
   logic             tick;
   logic [1:0]       led_nxt;
   logic [1:0]       steady_drive;

   // Assertion is immediate; release reaches the FSM two edges later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_s = rst_sync[1];

   // The input register runs off the raw reset so it samples on the first edge after release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mode_q <= MODE_OFF;
      else          mode_q <= mode_e'(led_ctrl);
   end

   assign mode_chg = (mode_q != mode_cur);

`ifdef CAR_LED_PWM_EN
   localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [STEP_W-1:0]   STEP_TC  = STEP_W'(STEP_DIV - 1);
   localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS-1:0] LVL_HALF = {1'b1, {(PWM_BITS-1){1'b0}}};

   logic [STEP_W-1:0]   step_cnt;
   logic [STEP_W-1:0]   step_nxt;
   logic                step_tc;
   logic [PWM_BITS-1:0] level;
   logic [PWM_BITS-1:0] level_nxt;
   logic [PWM_BITS-1:0] pwm_level;
   logic                pwm_out;

   assign pwm_level    = (state_nxt == ST_STEADY) ? LVL_HALF : level_nxt;
   assign steady_drive = {2{pwm_out}};

   car_led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
      .clk     (clk),
      .reset_n (rst_s),
      .level   (pwm_level),
      .pwm_out (pwm_out)
   );
`else
   assign steady_drive = 2'b11;
`endif

   always_comb begin
      tick      = (pre_cnt == PRE_TC);
      pre_nxt   = tick ? '0 : pre_cnt + PRE_W'(1);
      state_nxt = state;
`ifdef CAR_LED_PWM_EN
      step_tc   = (step_cnt == STEP_TC);
      step_nxt  = step_tc ? '0 : step_cnt + STEP_W'(1);
      level_nxt = level;
`endif
      // A mode change wins over any tick or step landing on the same cycle.
      if (mode_chg) begin
         pre_nxt   = '0;
         state_nxt = entry_state(mode_q);
`ifdef CAR_LED_PWM_EN
         step_nxt  = '0;
         level_nxt = '0;
`endif
      end else begin
         case (state)
            ST_BLINK_A: if (tick) state_nxt = ST_BLINK_B;
            ST_BLINK_B: if (tick) state_nxt = ST_BLINK_A;
`ifdef CAR_LED_PWM_EN
            ST_BREATHE_UP: if (step_tc) begin
               level_nxt = level + PWM_BITS'(1);
               if (level_nxt == LVL_MAX) state_nxt = ST_BREATHE_DN;
            end
            ST_BREATHE_DN: if (step_tc) begin
               level_nxt = level - PWM_BITS'(1);
               if (level_nxt == '0) state_nxt = ST_BREATHE_UP;
            end
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      led_nxt = 2'b00;
      case (state_nxt)
         ST_STEADY:     led_nxt = steady_drive;
         ST_BLINK_A:    led_nxt = 2'b01;
         ST_BLINK_B:    led_nxt = 2'b10;
`ifdef CAR_LED_PWM_EN
         ST_BREATHE_UP,
         ST_BREATHE_DN: led_nxt = {2{pwm_out}};
`endif
         default:       led_nxt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         state    <= ST_OFF;
         mode_cur <= MODE_OFF;
         pre_cnt  <= '0;
         led_out  <= 2'b00;
         active   <= 1'b0;
      end else begin
         state    <= state_nxt;
         mode_cur <= mode_q;
         pre_cnt  <= pre_nxt;
         led_out  <= led_nxt;
         active   <= (mode_q != MODE_OFF);
      end
   end

`ifdef CAR_LED_PWM_EN
   always_ff @(posedge clk or negedge rst_s) begin
      if (!rst_s) begin
         step_cnt <= '0;
         level    <= '0;
      end else begin
         step_cnt <= step_nxt;
         level    <= level_nxt;
      end
   end
`endif

endmodule

// File: doc/car_led_driver.md
CAR_LED_DRIVER -- requirements
Module: car_led_driver

Interface
REQ-001 Parameter CLK_HZ, default 50000000: clk frequency in Hz.
REQ-002 Parameter BLINK_HZ, default 2: blink toggle rate; half-period = CLK_HZ/(2*BLINK_HZ) cycles.
REQ-003 Parameter PWM_BITS, default 8: PWM counter and breathe-level width.
REQ-004 Parameter STEP_DIV, default 48828: clk cycles per breathe-level step.
REQ-005 clk  input  1  system clock, all logic rising-edge.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 led_ctrl  input  2  mode from the LED PIO output register, clk domain: 00 OFF, 01 STEADY, 10 BLINK, 11 BREATHE.
REQ-008 led_out  output  2  physical LED drive, active-high, registered.
REQ-009 active  output  1  high when the current mode is not OFF, registered.

Function
REQ-010 led_ctrl SHALL be registered once (mode_q); led_out and active SHALL be registered from mode_q, giving 2-cycle latency from a led_ctrl change to the output.
REQ-011 The FSM SHALL have states OFF, STEADY, BLINK_A, BLINK_B, BREATHE_UP, BREATHE_DN.
REQ-012 OFF: led_out=00.
REQ-013 STEADY: led_out=11, PWM-dimmed to fixed level 2^(PWM_BITS-1) when CAR_LED_PWM_EN is defined.
REQ-014 BLINK_A: led_out=01; BLINK_B: led_out=10; the state SHALL alternate on each half-period tick.
REQ-015 The half-period tick SHALL come from a prescaler counting 0..CLK_HZ/(2*BLINK_HZ)-1 that wraps to 0 and pulses the tick for one cycle at the terminal count.
REQ-016 BREATHE_UP/DN: both LEDs SHALL be PWM-driven at level L; L SHALL step +1 (UP) or -1 (DN) every STEP_DIV cycles.
REQ-017 UP SHALL go to DN on the step that makes L = 2^PWM_BITS-1; DN SHALL go to UP on the step that makes L = 0; L SHALL never wrap.
REQ-018 The PWM counter SHALL be free-running PWM_BITS wide and wrap to 0; an LED SHALL be on when counter < L, so L=0 is fully off.
REQ-019 Any mode_q change SHALL clear the prescaler, the step counter and L, and SHALL enter the entry state: OFF, STEADY, BLINK_A or BREATHE_UP.
REQ-020 A mode_q value equal to the previous value SHALL NOT restart timing.
REQ-021 A mode change coinciding with a tick SHALL take priority, and that tick SHALL be discarded.

Reset
REQ-022 While reset_n is low: led_out=00, active=0, mode_q=00, FSM=OFF, and all counters and L = 0.
REQ-023 Deassertion SHALL be synchronised to clk with a 2-flop synchroniser, and the first mode sample SHALL occur on the first clk edge after release.
REQ-024 Reset asserted mid-blink or mid-breathe SHALL immediately force led_out=00.

Configuration
REQ-025 Macro CAR_LED_PWM_EN, when defined, SHALL compile in the PWM counter, level L, STEADY dimming and breathe states.
REQ-026 When CAR_LED_PWM_EN is not defined, there SHALL be no PWM logic; STEADY SHALL drive 11 undimmed; mode 11 SHALL behave as STEADY; BREATHE_UP and BREATHE_DN SHALL be absent.

Structure
REQ-027 Package car_led_pkg SHALL hold the mode encoding enum (OFF/STEADY/BLINK/BREATHE) and the FSM state typedef.
REQ-028 Package car_led_pkg SHALL hold the default parameter constants.
REQ-029 The comparator and counter SHALL live in sub-module car_led_pwm (ports clk, reset_n, level, pwm_out), instantiated once and present only under CAR_LED_PWM_EN.
REQ-030 The top level SHALL hold the input register, prescaler, step counter and FSM.

Verification (CLK_HZ=1000, BLINK_HZ=50 -> half-period 10; PWM_BITS=4; STEP_DIV=2)
REQ-031 Reset: hold reset_n low with led_ctrl=01 -> led_out=00, active=0; after release, led_out=11 on the 2nd clk edge after the first sample.
REQ-032 Blink: set led_ctrl=10 -> led_out=01 for 10 cycles, then 10 for 10 cycles, repeating; active=1.
REQ-033 Breathe (PWM_EN): set led_ctrl=11 -> L reaches 15 after 30 cycles, then descends to 0 after 30 more; measured duty over 16 cycles equals L/16.
REQ-034 Mode change at tick: switch 10->01 on the tick cycle -> no BLINK_B; led_out=11 two cycles later; re-writing 10 during blink does not alter phase.
REQ-035 No PWM_EN: led_ctrl=11 -> led_out=11 constant.
REQ-036 Mid-op reset: assert reset_n low during BREATHE_DN at L=7 -> led_out=00 immediately; after release, L restarts at 0.
